// File: rtl/acc_rd_addr_gen_pkg.sv
// Shared types and project defaults for the accumulator read-address sequencer.
package acc_rd_addr_gen_pkg;

  typedef enum logic {
    RD_NORMAL = 1'b0,
    RD_DIAG   = 1'b1
  } acc_rd_mode_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_RUN,
    RD_DONE
  } acc_rd_state_t;

  localparam int ACC_ADDR_W = 7;
  localparam int ACC_COLS   = 32;

endpackage

// File: rtl/acc_rd_lane.sv
// One accumulator column: read enable and row address for beat k at a given skew.
module acc_rd_lane
  import acc_rd_addr_gen_pkg::*;
#(
  parameter int ADDR_W = ACC_ADDR_W,
  parameter int KW     = ADDR_W + 1
) (
  input  logic [KW-1:0]     k,
  input  logic [KW-1:0]     skew,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   n,
  input  acc_rd_mode_t      mode,
  output logic              en,
  output logic [ADDR_W-1:0] addr
);

  logic [KW-1:0] row;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    en   = 1'b0;
    addr = '0;
    row  = (mode == RD_DIAG) ? k - skew : k;
    if (mode == RD_NORMAL) begin
      en = 1'b1;
    end else begin
      en = (k >= skew) && (row < KW'(n));
    end
    // Truncation to ADDR_W bits is the intended modulo wrap of the bank address.
    if (en) begin
      addr = base + row[ADDR_W-1:0];
    end
  end

endmodule

// File: rtl/acc_rd_addr_gen.sv
// Accumulator read-address sequencer, NORMAL or DIAG column order with back-pressure.
// Optional build macro ACC_RD_ANTIDIAG_EN adds antidiag_i (reversed column skew in DIAG).
module acc_rd_addr_gen
  import acc_rd_addr_gen_pkg::*;
#(
  parameter int MUL_SIZE = ACC_COLS,
  parameter int ADDR_W   = ACC_ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic                       mode_i,
  input  logic [ADDR_W-1:0]          base_addr_i,
  input  logic [ADDR_W:0]            num_rows_i,
`ifdef ACC_RD_ANTIDIAG_EN
  input  logic                       antidiag_i,
`endif
  input  logic                       out_ready_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [MUL_SIZE-1:0]        rd_en_o,
  output logic [MUL_SIZE*ADDR_W-1:0] rd_addr_o
);

  localparam int KW = ADDR_W + 1 + $clog2(MUL_SIZE);

  acc_rd_state_t         state_q;
  acc_rd_mode_t          mode_q;
  logic [ADDR_W-1:0]     base_q;
  logic [ADDR_W:0]       n_q;
  logic [KW-1:0]         k_q;
  logic                  anti_q;

  acc_rd_mode_t          lane_mode;
  logic [ADDR_W-1:0]     lane_base;
  logic [ADDR_W:0]       lane_n;
  logic [KW-1:0]         lane_k;
  logic                  lane_anti;
  logic [MUL_SIZE-1:0]   lane_en;
  logic [MUL_SIZE*ADDR_W-1:0] lane_addr;
  logic [KW-1:0]         t_total;
  logic                  last_beat;
  logic                  start_anti;

`ifdef ACC_RD_ANTIDIAG_EN
  assign start_anti = antidiag_i;
`else
  assign start_anti = 1'b0;
`endif

  // Lanes evaluate the beat that will be presented after the next edge, so the
  // registered outputs show beat 0 one cycle after start and beat k+1 right after an accept.
  always_comb begin
    lane_mode = mode_q;
    lane_base = base_q;
    lane_n    = n_q;
    lane_anti = anti_q;
    lane_k    = k_q + KW'(1);
    if (state_q == RD_IDLE) begin
      lane_mode = acc_rd_mode_t'(mode_i);
      lane_base = base_addr_i;
      lane_n    = num_rows_i;
      lane_anti = start_anti;
      lane_k    = '0;
    end
  end

  assign t_total   = KW'(n_q) + ((mode_q == RD_DIAG) ? KW'(MUL_SIZE - 1) : '0);
  assign last_beat = (k_q == t_total - KW'(1));

  for (genvar c = 0; c < MUL_SIZE; c++) begin : g_lane
    logic [KW-1:0] skew;
    assign skew = lane_anti ? KW'(MUL_SIZE - 1 - c) : KW'(c);

    acc_rd_lane #(
      .ADDR_W(ADDR_W),
      .KW    (KW)
    ) u_lane (
      .k   (lane_k),
      .skew(skew),
      .base(lane_base),
      .n   (lane_n),
      .mode(lane_mode),
      .en  (lane_en[c]),
      .addr(lane_addr[c*ADDR_W +: ADDR_W])
    );
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RD_IDLE;
      mode_q    <= RD_NORMAL;
      base_q    <= '0;
      n_q       <= '0;
      k_q       <= '0;
      anti_q    <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      rd_en_o   <= '0;
      rd_addr_o <= '0;
    end else begin
      case (state_q)
        RD_IDLE: begin
          if (start_i) begin
            mode_q <= lane_mode;
            base_q <= lane_base;
            n_q    <= lane_n;
            anti_q <= lane_anti;
            k_q    <= '0;
            busy_o <= 1'b1;
            if (num_rows_i != '0) begin
              state_q   <= RD_RUN;
              rd_en_o   <= lane_en;
              rd_addr_o <= lane_addr;
            end else begin
              state_q <= RD_DONE;
              done_o  <= 1'b1;
            end
          end
        end
        RD_RUN: begin
          // Without out_ready_i nothing is written, so every output holds its beat.
          if (out_ready_i) begin
            if (last_beat) begin
              state_q   <= RD_DONE;
              done_o    <= 1'b1;
              rd_en_o   <= '0;
              rd_addr_o <= '0;
            end else begin
              k_q       <= lane_k;
              rd_en_o   <= lane_en;
              rd_addr_o <= lane_addr;
            end
          end
        end
        RD_DONE: begin
          state_q <= RD_IDLE;
          done_o  <= 1'b0;
          busy_o  <= 1'b0;
        end
        default: state_q <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_rd_addr_gen.sv
// Self-checking bench for acc_rd_addr_gen (MUL_SIZE=4, ADDR_W=4) against a per-beat reference model.
module tb_acc_rd_addr_gen;

  localparam int MS = 4;
  localparam int AW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start_i;
  logic           mode_i;
  logic [AW-1:0]  base_addr_i;
  logic [AW:0]    num_rows_i;
  logic           antidiag_i;
  logic           out_ready_i;
  logic           busy_o;
  logic           done_o;
  logic [MS-1:0]  rd_en_o;
  logic [MS*AW-1:0] rd_addr_o;

  int checks   = 0;
  int failures = 0;

  logic [MS-1:0]    obs_en[$];
  logic [MS*AW-1:0] obs_addr[$];

  acc_rd_addr_gen #(
    .MUL_SIZE(MS),
    .ADDR_W  (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .mode_i     (mode_i),
    .base_addr_i(base_addr_i),
    .num_rows_i (num_rows_i),
`ifdef ACC_RD_ANTIDIAG_EN
    .antidiag_i (antidiag_i),
`endif
    .out_ready_i(out_ready_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .rd_en_o    (rd_en_o),
    .rd_addr_o  (rd_addr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Beat k of a sequence: column c reads row (k - skew) when that row is one of the N requested.
  function automatic void model_beat(input int mode, input int base, input int n, input int anti,
                                     input int k, output logic [MS-1:0] en,
                                     output logic [MS*AW-1:0] addr);
    int row;
    en   = '0;
    addr = '0;
    for (int c = 0; c < MS; c++) begin
      if (mode == 0) row = k;
      else row = k - ((anti != 0) ? (MS - 1 - c) : c);
      if (row >= 0 && row < n) begin
        en[c] = 1'b1;
        addr[c*AW +: AW] = AW'((base + row) % (1 << AW));
      end
    end
  endfunction

  // Runs one sequence with optional forced stall and random back-pressure; junk start pulses
  // are thrown in while busy and must be ignored.
  task automatic run_seq(input int mode, input int base, input int n, input int anti,
                         input int stall_k, input int stall_len, input int rand_pct,
                         output int beat_cycles);
    int t, k, stalled, budget;
    logic acc;
    logic [MS-1:0] een;
    logic [MS*AW-1:0] eaddr;
    t = (n == 0) ? 0 : ((mode != 0) ? n + MS - 1 : n);
    obs_en.delete();
    obs_addr.delete();
    @(negedge clk);
    start_i     = 1'b1;
    mode_i      = 1'(mode);
    base_addr_i = AW'(base);
    num_rows_i  = (AW+1)'(n);
    antidiag_i  = 1'(anti);
    out_ready_i = 1'($urandom_range(1));
    @(negedge clk);
    k = 0; stalled = 0; budget = 400; beat_cycles = 0;
    while (k < t && budget > 0) begin
      model_beat(mode, base, n, anti, k, een, eaddr);
      check("busy_in_run", busy_o, 1'b1);
      check("done_in_run", done_o, 1'b0);
      check("rd_en", rd_en_o, een);
      check("rd_addr", rd_addr_o, eaddr);
      start_i     = 1'($urandom_range(1));
      mode_i      = 1'($urandom_range(1));
      base_addr_i = AW'($urandom_range(15));
      num_rows_i  = (AW+1)'($urandom_range(16));
      if (k == stall_k && stalled < stall_len) begin
        out_ready_i = 1'b0;
        stalled++;
      end else begin
        out_ready_i = ($urandom_range(99) >= rand_pct);
      end
      acc = out_ready_i;
      if (acc) begin
        obs_en.push_back(rd_en_o);
        obs_addr.push_back(rd_addr_o);
      end
      @(negedge clk);
      beat_cycles++;
      budget--;
      if (acc) k++;
    end
    if (budget == 0) check("run_timeout", 32'(k), 32'(t));
    start_i = 1'b0;
    check("done_pulse", done_o, 1'b1);
    check("busy_in_done", busy_o, 1'b1);
    check("rd_en_after_last", rd_en_o, '0);
    out_ready_i = 1'($urandom_range(1));
    @(negedge clk);
    check("done_single_cycle", done_o, 1'b0);
    check("busy_after_done", busy_o, 1'b0);
  endtask

  initial begin
    int bc;
    int hits[MS][16];
    logic [MS-1:0] diag_tab[6];
    rst_n = 1'b0; start_i = 1'b0; mode_i = 1'b0; base_addr_i = '0;
    num_rows_i = '0; antidiag_i = 1'b0; out_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_en", rd_en_o, '0);
    check("rst_addr", rd_addr_o, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // NORMAL base=3 N=5: addresses 3..7 on all columns, 5 beat cycles then done.
    run_seq(0, 3, 5, 0, -1, 0, 0, bc);
    check("normal_beats", 32'(bc), 32'd5);
    check("normal_col3_beat4", 32'(obs_addr[4][15:12]), 32'd7);

    // DIAG base=0 N=3: six beats with the skewed enable pattern.
    diag_tab = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
    run_seq(1, 0, 3, 0, -1, 0, 0, bc);
    check("diag_beats", 32'(bc), 32'd6);
    for (int i = 0; i < 6; i++) check("diag_en_seq", obs_en[i], diag_tab[i]);
    for (int i = 2; i <= 4; i++) check("diag_col2_addr", 32'(obs_addr[i][11:8]), 32'(i - 2));

    // Same DIAG sequence with a two-cycle stall at beat 2.
    run_seq(1, 0, 3, 0, 2, 2, 0, bc);
    check("diag_stall_cycles", 32'(bc), 32'd8);
    for (int i = 0; i < 6; i++) check("diag_stall_en_seq", obs_en[i], diag_tab[i]);

    // Wrap: base=14 N=4 -> 14,15,0,1.
    run_seq(0, 14, 4, 0, -1, 0, 0, bc);
    check("wrap_b0", 32'(obs_addr[0][3:0]), 32'd14);
    check("wrap_b2", 32'(obs_addr[2][3:0]), 32'd0);
    check("wrap_b3", 32'(obs_addr[3][3:0]), 32'd1);

    // Full depth in DIAG with back-pressure: each column reads every row exactly once.
    run_seq(1, 9, 16, 0, -1, 0, 30, bc);
    foreach (hits[c, r]) hits[c][r] = 0;
    for (int i = 0; i < obs_en.size(); i++)
      for (int c = 0; c < MS; c++)
        if (obs_en[i][c]) hits[c][int'(obs_addr[i][c*AW +: AW])]++;
    for (int c = 0; c < MS; c++)
      for (int r = 0; r < 16; r++) check("full_depth_once", 32'(hits[c][r]), 32'd1);

    // N=0: no beat, done right after the start edge.
    run_seq(1, 5, 0, 0, -1, 0, 0, bc);
    check("n0_no_beats", 32'(obs_en.size()), 32'd0);

`ifdef ACC_RD_ANTIDIAG_EN
    diag_tab = '{4'b1000, 4'b1100, 4'b1110, 4'b0111, 4'b0011, 4'b0001};
    run_seq(1, 0, 3, 1, -1, 0, 0, bc);
    for (int i = 0; i < 6; i++) check("antidiag_en_seq", obs_en[i], diag_tab[i]);
`endif

    // Random sequences against the model.
    for (int i = 0; i < 25; i++) begin
`ifdef ACC_RD_ANTIDIAG_EN
      run_seq($urandom_range(1), $urandom_range(15), $urandom_range(16), $urandom_range(1),
              -1, 0, 35, bc);
`else
      run_seq($urandom_range(1), $urandom_range(15), $urandom_range(16), 0, -1, 0, 35, bc);
`endif
    end

    // Reset mid-RUN: outputs clear immediately and no done pulse follows.
    @(negedge clk);
    start_i = 1'b1; mode_i = 1'b0; base_addr_i = 4'd2; num_rows_i = 5'd10; out_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_busy", busy_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy_o, 1'b0);
    check("midrst_en", rd_en_o, '0);
    check("midrst_addr", rd_addr_o, '0);
    check("midrst_done", done_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_done", done_o, 1'b0);
      check("post_rst_busy", busy_o, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
